snow64_pipe_stage_ex: RTL
=========================

Name: snow64_pipe_stage_ex

Overview:
- Execute stage of the Snow64 pipeline, between IF/ID (upstream) and WB (downstream).
- Consumes decoded instruction fields plus operand data from IF/ID.
- For group 0 (ALU/Mul/Div), computes a 64-bit result; for groups 2/3 (loads/stores), computes the effective address.
- Registers both, with group and ra_index, for WB; propagates WB back-pressure and its own multi-cycle divide stall to IF/ID.

Parameters:
- DATA_WIDTH, 64, operand/result/address width.
- DIV_CYCLES, 64, iterations of the unsigned divider (one quotient bit per cycle).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- in_valid  in  1  IF/ID presents an instruction this cycle.
- in_group  in  3  instruction group: 0 ALU, 1 control, 2 load, 3 store.
- in_alu_op  in  4  ALU operation, group 0 only.
- in_ra_index  in  4  destination/ld-st LAR index, forwarded unchanged.
- in_rb_data  in  64  operand B.
- in_rc_data  in  64  operand C.
- in_simm12  in  12  signed immediate.
- in_stall_from_wb  in  1  WB cannot accept a new instruction.
- out_stall_to_if_id  out  1  IF/ID must hold its current instruction.
- out_valid  out  1  output fields hold an instruction for WB.
- out_group  out  3  registered in_group.
- out_ra_index  out  4  registered in_ra_index.
- out_computed_data  out  64  group-0 result, else 0.
- out_ldst_addr  out  64  groups 2/3 effective address, else 0.

Behaviour:
- Reset (rst_n low, asynchronous):
  - all outputs 0, except out_stall_to_if_id, which follows the combinational equation below;
  - state StRegular; divider cleared.
  - Reset mid-divide aborts the divide with no output.
- ALU op encoding:
  - 0 Add, 1 Sub (rb−rc), 2 And, 3 Or, 4 Xor;
  - 5 Shl, 6 Shr logical, 7 Sar; shift amount is rc[5:0];
  - 8 Mul (low 64 bits of rb*rc), 9 DivU (rb/rc unsigned);
  - 10–15 produce 0.
  - All arithmetic wraps modulo 2^64.
- ldst_addr = rb + rc + sign_extend(simm12), wrapping modulo 2^64.
- out_stall_to_if_id = (state==StDiv) || in_stall_from_wb. This is combinational.
- accept = in_valid && !out_stall_to_if_id.
- State StRegular:
  - If in_stall_from_wb: all output registers hold.
  - Else if accept and not (group 0 and op DivU): outputs load next edge; out_valid=1. Latency is 1 cycle.
  - Else if accept and DivU: go to StDiv; latch operands, ra_index and group; out_valid<=0.
  - Else: out_valid<=0; other outputs hold.
- State StDiv:
  - Divider iterates DIV_CYCLES cycles.
  - On divider done and !in_stall_from_wb: load quotient into out_computed_data; out_valid=1; return to StRegular. Total latency is DIV_CYCLES+1 edges from accept.
  - If in_stall_from_wb when done, remain in StDiv with the result held until it drops.
- Divide by zero: quotient all-ones. Takes the same cycle count.
- Group 1: passes through with out_valid=1, computed_data=0, ldst_addr=0. WB ignores it.
- Back-to-back instructions sustain 1 per cycle while no stall and no DivU.

Optional Feature:
- Macro SNOW64_PIPE_STAGE_EX_DIV_EN.
- Defined: iterative DivU as described above, with StDiv state and sub-module.
- Undefined:
  - DivU completes in 1 cycle with result all-ones, like any single-cycle op;
  - no StDiv state and no divider is instantiated;
  - out_stall_to_if_id = in_stall_from_wb.

Decomposition:
- Package PkgSnow64PipeStageEx holds:
  - AluOp enum (widths 4);
  - group constants (GroupAlu=0, GroupCtrl=1, GroupLd=2, GroupSt=3);
  - PortIn/PortOut structs for the IF/ID-to-EX and EX-to-WB bundles;
  - State enum {StRegular, StDiv}.
- Sub-module snow64_iter_divider: restoring unsigned divider with start/busy/done handshake.
  - start pulses one cycle;
  - done is held until ack;
  - an rc==0 check yields all-ones.

Test Plan:
- Add, rb=0xFFFF_FFFF_FFFF_FFFF, rc=1, ra=5 -> next cycle out_valid=1, computed_data=0, ra_index=5.
- Load, rb=0x1000, rc=0x20, simm12=0xFFC (−4) -> ldst_addr=0x101C, computed_data=0, group=2.
- in_stall_from_wb held 3 cycles after a Sub result is registered -> outputs unchanged for 3 cycles, out_stall_to_if_id=1, and the next in_valid is not consumed until the stall drops.
- DivU rb=100, rc=7 (feature on) -> out_stall_to_if_id=1 for 64 cycles, then computed_data=14, out_valid=1 at edge 65. With rc=0, computed_data=all-ones. Feature off: all-ones after 1 cycle.
- rst_n pulled low at divide cycle 30 -> outputs 0 immediately, state StRegular; the following Xor 0xF0^0x0F yields 0xFF after 1 cycle.
- Sar rb=0x8000_0000_0000_0000, rc=0x43 (amount 3) -> 0xF000_0000_0000_0000.

Source files
------------

// File: rtl/snow64_pipe_stage_ex_pkg.sv
// Shared types for the Snow64 execute stage: ALU opcodes, instruction groups,
// IF/ID-to-EX and EX-to-WB bundles, and the stage FSM states.
package PkgSnow64PipeStageEx;

  localparam int DataWidth = 64;

  typedef enum logic [3:0] {
    OpAdd  = 4'd0,
    OpSub  = 4'd1,
    OpAnd  = 4'd2,
    OpOr   = 4'd3,
    OpXor  = 4'd4,
    OpShl  = 4'd5,
    OpShr  = 4'd6,
    OpSar  = 4'd7,
    OpMul  = 4'd8,
    OpDivU = 4'd9
  } AluOp;

  localparam logic [2:0] GroupAlu  = 3'd0;
  localparam logic [2:0] GroupCtrl = 3'd1;
  localparam logic [2:0] GroupLd   = 3'd2;
  localparam logic [2:0] GroupSt   = 3'd3;

  typedef struct packed {
    logic                 valid;
    logic [2:0]           group;
    AluOp                 alu_op;
    logic [3:0]           ra_index;
    logic [DataWidth-1:0] rb_data;
    logic [DataWidth-1:0] rc_data;
    logic [11:0]          simm12;
  } PortIn;

  typedef struct packed {
    logic                 valid;
    logic [2:0]           group;
    logic [3:0]           ra_index;
    logic [DataWidth-1:0] computed_data;
    logic [DataWidth-1:0] ldst_addr;
  } PortOut;

  typedef enum logic {
    StRegular = 1'b0,
    StDiv     = 1'b1
  } State;

endpackage

// File: rtl/snow64_pipe_stage_ex_divider.sv
// Restoring unsigned divider, one quotient bit per cycle. The first bit is
// produced on the start edge so CYCLES edges after start the quotient is ready.
module snow64_iter_divider #(
  parameter int WIDTH  = 64,
  parameter int CYCLES = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             ack_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] quotient_o
);

  localparam int CntW = $clog2(CYCLES + 1);

  // Returns {remainder, quotient} after shifting in one dividend bit.
  function automatic logic [2*WIDTH-1:0] div_step(input logic [WIDTH-1:0] rem,
                                                  input logic [WIDTH-1:0] quo,
                                                  input logic [WIDTH-1:0] dvs);
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;
    shifted = {rem, quo[WIDTH-1]};
    diff    = shifted - {1'b0, dvs};
    if (diff[WIDTH]) return {shifted[WIDTH-1:0], quo[WIDTH-2:0], 1'b0};
    return {diff[WIDTH-1:0], quo[WIDTH-2:0], 1'b1};
  endfunction

  logic             busy_q, busy_d;
  logic             zero_q, zero_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;

  assign busy_o     = busy_q;
  assign done_o     = busy_q && (cnt_q == '0);
  assign quotient_o = zero_q ? '1 : quo_q;

  always_comb begin
    busy_d = busy_q;
    zero_d = zero_q;
    cnt_d  = cnt_q;
    rem_d  = rem_q;
    quo_d  = quo_q;
    dvs_d  = dvs_q;
    if (start_i) begin
      {rem_d, quo_d} = div_step('0, dividend_i, divisor_i);
      dvs_d          = divisor_i;
      zero_d         = (divisor_i == '0);
      cnt_d          = CntW'(CYCLES - 1);
      busy_d         = 1'b1;
    end else if (busy_q && (cnt_q != '0)) begin
      {rem_d, quo_d} = div_step(rem_q, quo_q, dvs_q);
      cnt_d          = cnt_q - CntW'(1);
    end else if (done_o && ack_i) begin
      busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      zero_q <= 1'b0;
      cnt_q  <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
    end else begin
      busy_q <= busy_d;
      zero_q <= zero_d;
      cnt_q  <= cnt_d;
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dvs_q  <= dvs_d;
    end
  end

endmodule

// File: rtl/snow64_pipe_stage_ex.sv
// Snow64 execute stage: ALU result / load-store address registered for WB.
// Define SNOW64_PIPE_STAGE_EX_DIV_EN for the iterative DivU; otherwise DivU
// is a single-cycle op returning all-ones.
module snow64_pipe_stage_ex
  import PkgSnow64PipeStageEx::*;
#(
  parameter int DATA_WIDTH = 64
`ifdef SNOW64_PIPE_STAGE_EX_DIV_EN
  , parameter int DIV_CYCLES = 64
`endif
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [2:0]            in_group,
  input  logic [3:0]            in_alu_op,
  input  logic [3:0]            in_ra_index,
  input  logic [DATA_WIDTH-1:0] in_rb_data,
  input  logic [DATA_WIDTH-1:0] in_rc_data,
  input  logic [11:0]           in_simm12,
  input  logic                  in_stall_from_wb,
  output logic                  out_stall_to_if_id,
  output logic                  out_valid,
  output logic [2:0]            out_group,
  output logic [3:0]            out_ra_index,
  output logic [DATA_WIDTH-1:0] out_computed_data,
  output logic [DATA_WIDTH-1:0] out_ldst_addr
);

  PortIn                 in_bus;
  PortOut                out_q, out_d, fresh;
  logic                  accept;
  logic [DATA_WIDTH-1:0] alu_res;
  logic [DATA_WIDTH-1:0] eff_addr;
  logic [5:0]            shamt;

  assign in_bus = '{valid: in_valid, group: in_group, alu_op: AluOp'(in_alu_op),
                    ra_index: in_ra_index, rb_data: in_rb_data,
                    rc_data: in_rc_data, simm12: in_simm12};

  assign accept   = in_bus.valid && !out_stall_to_if_id;
  assign shamt    = in_bus.rc_data[5:0];
  assign eff_addr = in_bus.rb_data + in_bus.rc_data
                  + {{(DATA_WIDTH-12){in_bus.simm12[11]}}, in_bus.simm12};

  always_comb begin
    alu_res = '0;
    case (in_bus.alu_op)
      OpAdd:   alu_res = in_bus.rb_data + in_bus.rc_data;
      OpSub:   alu_res = in_bus.rb_data - in_bus.rc_data;
      OpAnd:   alu_res = in_bus.rb_data & in_bus.rc_data;
      OpOr:    alu_res = in_bus.rb_data | in_bus.rc_data;
      OpXor:   alu_res = in_bus.rb_data ^ in_bus.rc_data;
      OpShl:   alu_res = in_bus.rb_data << shamt;
      OpShr:   alu_res = in_bus.rb_data >> shamt;
      OpSar:   alu_res = $signed(in_bus.rb_data) >>> shamt;
      OpMul:   alu_res = in_bus.rb_data * in_bus.rc_data;
      OpDivU:  alu_res = '1;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    fresh = '{valid: 1'b1, group: in_bus.group, ra_index: in_bus.ra_index,
              computed_data: (in_bus.group == GroupAlu) ? alu_res : '0,
              ldst_addr: ((in_bus.group == GroupLd) || (in_bus.group == GroupSt))
                         ? eff_addr : '0};
  end

`ifdef SNOW64_PIPE_STAGE_EX_DIV_EN
  State                  state_q, state_d;
  logic [3:0]            pend_ra_q, pend_ra_d;
  logic [2:0]            pend_group_q, pend_group_d;
  logic                  is_divu;
  logic                  div_start, div_ack, div_busy, div_done;
  logic [DATA_WIDTH-1:0] div_quotient;

  assign is_divu            = (in_bus.group == GroupAlu) && (in_bus.alu_op == OpDivU);
  assign out_stall_to_if_id = (state_q == StDiv) || in_stall_from_wb;

  snow64_iter_divider #(.WIDTH(DATA_WIDTH), .CYCLES(DIV_CYCLES)) u_divider (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (div_start),
    .ack_i      (div_ack),
    .dividend_i (in_bus.rb_data),
    .divisor_i  (in_bus.rc_data),
    .busy_o     (div_busy),
    .done_o     (div_done),
    .quotient_o (div_quotient)
  );

  always_comb begin
    out_d        = out_q;
    state_d      = state_q;
    pend_ra_d    = pend_ra_q;
    pend_group_d = pend_group_q;
    div_start    = 1'b0;
    div_ack      = 1'b0;
    case (state_q)
      StRegular: begin
        if (!in_stall_from_wb) begin
          if (accept && is_divu) begin
            state_d      = StDiv;
            pend_ra_d    = in_bus.ra_index;
            pend_group_d = in_bus.group;
            div_start    = 1'b1;
            out_d.valid  = 1'b0;
          end else if (accept) begin
            out_d = fresh;
          end else begin
            out_d.valid = 1'b0;
          end
        end
      end
      StDiv: begin
        // A divider that is not busy here can only mean a lost divide; recover.
        if (!div_busy) begin
          state_d = StRegular;
        end else if (div_done && !in_stall_from_wb) begin
          out_d   = '{valid: 1'b1, group: pend_group_q, ra_index: pend_ra_q,
                      computed_data: div_quotient, ldst_addr: '0};
          div_ack = 1'b1;
          state_d = StRegular;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StRegular;
      pend_ra_q    <= '0;
      pend_group_q <= '0;
    end else begin
      state_q      <= state_d;
      pend_ra_q    <= pend_ra_d;
      pend_group_q <= pend_group_d;
    end
  end
`else
  assign out_stall_to_if_id = in_stall_from_wb;

  always_comb begin
    out_d = out_q;
    if (!in_stall_from_wb) begin
      if (accept) out_d = fresh;
      else        out_d.valid = 1'b0;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out_q <= '0;
    else        out_q <= out_d;
  end

  assign out_valid         = out_q.valid;
  assign out_group         = out_q.group;
  assign out_ra_index      = out_q.ra_index;
  assign out_computed_data = out_q.computed_data;
  assign out_ldst_addr     = out_q.ldst_addr;

endmodule
